// File: rtl/fpu_pkg.sv
// Shared FP R-type constants, datapath op encodings and the sequencer state type.
// Funct7 decode lives here so the decoder and the sequencer agree on what is legal.
package fpu_pkg;

   localparam logic [6:0] FP_OPCODE = 7'b1010011;

   localparam logic [6:0] F7_FADD = 7'b0000000;
   localparam logic [6:0] F7_FSUB = 7'b0000100;
   localparam logic [6:0] F7_FMUL = 7'b0001000;
   localparam logic [6:0] F7_FDIV = 7'b0001100;

   localparam logic [1:0] UOP_ADD = 2'b00;
   localparam logic [1:0] UOP_SUB = 2'b01;
   localparam logic [1:0] UOP_MUL = 2'b10;
   localparam logic [1:0] UOP_DIV = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_WB   = 2'd2
   } fpu_state_e;

   typedef struct packed {
      logic       legal;
      logic [1:0] op;
   } f7_dec_t;

   function automatic f7_dec_t decode_f7(input logic [6:0] f7);
      f7_dec_t d;
      d.legal = 1'b1;
      d.op    = UOP_ADD;
      case (f7)
         F7_FADD: d.op = UOP_ADD;
         F7_FSUB: d.op = UOP_SUB;
         F7_FMUL: d.op = UOP_MUL;
         F7_FDIV: d.op = UOP_DIV;
         default: d.legal = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/fpu_seq.sv
// Launches one FP R-type op on a fixed-latency datapath, stalls fetch/decode for LAT+1 cycles,
// then writes the captured result to the FP register file for one cycle; Flush/reset abandon the op.
module fpu_seq
   import fpu_pkg::*;
#(
   parameter int ADD_LAT = 3,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        FPStart,
   input  logic [6:0]  Funct7,
   input  logic [4:0]  RdIn,
   input  logic        Flush,
   output logic        Stall,
   output logic        UnitStart,
   output logic [1:0]  UnitOp,
   input  logic [31:0] UnitResult,
   output logic        FRegWrite,
   output logic [4:0]  FRd,
   output logic [31:0] FResult,
   output logic        IllegalOp
);

   localparam int MAX_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
   localparam int MAX_LAT = (MAX_AM > DIV_LAT) ? MAX_AM : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);

   fpu_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    op_q, op_d;
   logic [4:0]    rd_q, rd_d;
   logic [31:0]   res_q, res_d;

   f7_dec_t       dec;
   logic [CW-1:0] lat_m1;
   logic          kill;

   assign dec  = decode_f7(Funct7);
   assign kill = reset | Flush;

   always_comb begin
      case (dec.op)
         UOP_MUL: lat_m1 = CW'(MUL_LAT - 1);
         UOP_DIV: lat_m1 = CW'(DIV_LAT - 1);
         default: lat_m1 = CW'(ADD_LAT - 1);
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      rd_d      = rd_q;
      res_d     = res_q;
      Stall     = 1'b0;
      UnitStart = 1'b0;
      UnitOp    = 2'b00;
      FRegWrite = 1'b0;
      FRd       = 5'd0;
      FResult   = 32'd0;
      IllegalOp = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (FPStart && !kill) begin
               if (dec.legal) begin
                  Stall     = 1'b1;
                  UnitStart = 1'b1;
                  UnitOp    = dec.op;
                  op_d      = dec.op;
                  rd_d      = RdIn;
                  cnt_d     = lat_m1;
                  state_d   = S_RUN;
               end else begin
                  IllegalOp = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (!kill) begin
               Stall  = 1'b1;
               UnitOp = op_q;
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CW'(1);
               end else begin
                  res_d   = UnitResult;
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            // FPStart here still belongs to the instruction being retired.
            if (!kill) begin
               FRegWrite = 1'b1;
               FRd       = rd_q;
               FResult   = res_q;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (kill) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= 2'b00;
         rd_q    <= 5'd0;
         res_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         res_q   <= res_d;
      end
   end

endmodule

// File: tb/tb_fpu_seq.sv
// Scoreboard bench for fpu_seq: expected writes are queued at launch and matched against FRegWrite.
module tb_fpu_seq;
   import fpu_pkg::*;

   localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset;
   logic        FPStart;
   logic [6:0]  Funct7;
   logic [4:0]  RdIn;
   logic        Flush;
   logic        Stall;
   logic        UnitStart;
   logic [1:0]  UnitOp;
   logic [31:0] UnitResult;
   logic        FRegWrite;
   logic [4:0]  FRd;
   logic [31:0] FResult;
   logic        IllegalOp;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] res;
   } wr_t;

   wr_t exp_q[$];
   int  start_cyc[$];
   int  cyc = 0;
   int  n_cmp = 0;
   int  n_err = 0;

   fpu_seq dut (
      .clk       (clk),
      .reset     (reset),
      .FPStart   (FPStart),
      .Funct7    (Funct7),
      .RdIn      (RdIn),
      .Flush     (Flush),
      .Stall     (Stall),
      .UnitStart (UnitStart),
      .UnitOp    (UnitOp),
      .UnitResult(UnitResult),
      .FRegWrite (FRegWrite),
      .FRd       (FRd),
      .FResult   (FResult),
      .IllegalOp (IllegalOp)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Write-port monitor: every FRegWrite must match the oldest queued launch.
   initial begin
      forever begin
         @(negedge clk);
         if (UnitStart === 1'b1) start_cyc.push_back(cyc);
         if (FRegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk_eq("unexpected_frw", 32'(FRegWrite), 32'd0);
            end else begin
               wr_t w;
               w = exp_q.pop_front();
               chk_eq("wb_frd", 32'(FRd), 32'(w.rd));
               chk_eq("wb_fresult", FResult, w.res);
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk_eq({tag, "_stall"}, 32'(Stall), 0);
      chk_eq({tag, "_ustart"}, 32'(UnitStart), 0);
      chk_eq({tag, "_uop"}, 32'(UnitOp), 0);
      chk_eq({tag, "_frw"}, 32'(FRegWrite), 0);
      chk_eq({tag, "_frd"}, 32'(FRd), 0);
      chk_eq({tag, "_fres"}, FResult, 0);
      chk_eq({tag, "_ill"}, 32'(IllegalOp), 0);
   endtask

   // Called just after a rising edge; returns just after the edge that starts the IDLE cycle after WB.
   task automatic fp_op(input logic [6:0] f7, input logic [4:0] rd, input logic [31:0] res,
                        input int lat, input logic [1:0] op, input bit hold_wb);
      FPStart = 1'b1;
      Funct7 = f7;
      RdIn = rd;
      UnitResult = JUNK;
      @(negedge clk);
      chk_eq("launch_ustart", 32'(UnitStart), 1);
      chk_eq("launch_stall", 32'(Stall), 1);
      chk_eq("launch_uop", 32'(UnitOp), 32'(op));
      exp_q.push_back({rd, res});
      for (int i = 1; i <= lat; i++) begin
         next_cycle();
         FPStart = 1'b0;
         RdIn = 5'd31;
         UnitResult = (i == lat) ? res : JUNK;
         @(negedge clk);
         chk_eq("run_stall", 32'(Stall), 1);
         chk_eq("run_ustart", 32'(UnitStart), 0);
         chk_eq("run_uop", 32'(UnitOp), 32'(op));
         chk_eq("run_frw", 32'(FRegWrite), 0);
      end
      next_cycle();
      UnitResult = JUNK;
      FPStart = hold_wb;
      @(negedge clk);
      chk_eq("wb_stall", 32'(Stall), 0);
      chk_eq("wb_frw", 32'(FRegWrite), 1);
      chk_eq("wb_ustart", 32'(UnitStart), 0);
      next_cycle();
   endtask

   initial begin
      int n0;
      reset = 1'b1;
      FPStart = 1'b0;
      Funct7 = F7_FADD;
      RdIn = 5'd0;
      Flush = 1'b0;
      UnitResult = JUNK;

      // Reset state, including a legal FPStart held during reset.
      next_cycle();
      @(negedge clk);
      chk_all_zero("rst");
      FPStart = 1'b1;
      @(negedge clk);
      chk_all_zero("rst_fpstart");
      next_cycle();
      FPStart = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      chk_all_zero("idle");
      next_cycle();

      // FADD, default latency 3
      fp_op(F7_FADD, 5'd5, 32'h4040_0000, 3, UOP_ADD, 1'b0);
      @(negedge clk);
      chk_all_zero("post_fadd");
      next_cycle();

      // FDIV with FPStart held in WB: no relaunch
      fp_op(F7_FDIV, 5'd12, 32'h3F2A_AAAB, 12, UOP_DIV, 1'b1);
      FPStart = 1'b0;
      @(negedge clk);
      chk_eq("fdiv_no_relaunch", 32'(Stall), 0);
      next_cycle();

      // FMUL flushed two cycles after launch
      FPStart = 1'b1;
      Funct7 = F7_FMUL;
      RdIn = 5'd3;
      @(negedge clk);
      chk_eq("fmul_ustart", 32'(UnitStart), 1);
      chk_eq("fmul_uop", 32'(UnitOp), 32'(UOP_MUL));
      next_cycle();
      FPStart = 1'b0;
      @(negedge clk);
      chk_eq("fmul_run_stall", 32'(Stall), 1);
      next_cycle();
      Flush = 1'b1;
      @(negedge clk);
      chk_eq("flush_stall", 32'(Stall), 0);
      chk_eq("flush_ustart", 32'(UnitStart), 0);
      next_cycle();
      Flush = 1'b0;
      @(negedge clk);
      chk_eq("post_flush_stall", 32'(Stall), 0);
      next_cycle();
      UnitResult = 32'h1234_5678;
      next_cycle();
      UnitResult = JUNK;
      repeat (3) next_cycle();

      // Flush beats FPStart in IDLE
      FPStart = 1'b1;
      Funct7 = F7_FADD;
      Flush = 1'b1;
      @(negedge clk);
      chk_eq("flush_prio_ustart", 32'(UnitStart), 0);
      chk_eq("flush_prio_stall", 32'(Stall), 0);
      next_cycle();
      FPStart = 1'b0;
      Flush = 1'b0;
      @(negedge clk);
      chk_eq("flush_prio_idle", 32'(Stall), 0);
      next_cycle();

      // Illegal Funct7
      FPStart = 1'b1;
      Funct7 = 7'b0000001;
      @(negedge clk);
      chk_eq("ill_pulse", 32'(IllegalOp), 1);
      chk_eq("ill_stall", 32'(Stall), 0);
      chk_eq("ill_ustart", 32'(UnitStart), 0);
      next_cycle();
      FPStart = 1'b0;
      @(negedge clk);
      chk_eq("ill_pulse_end", 32'(IllegalOp), 0);
      next_cycle();

      // FSUB then FADD back to back with FPStart held
      n0 = start_cyc.size();
      fp_op(F7_FSUB, 5'd7, 32'hC000_0000, 3, UOP_SUB, 1'b1);
      fp_op(F7_FADD, 5'd8, 32'h4100_0000, 3, UOP_ADD, 1'b0);
      FPStart = 1'b0;
      if (start_cyc.size() >= n0 + 2)
         chk_eq("b2b_interval", 32'(start_cyc[n0+1] - start_cyc[n0]), 32'd5);
      else
         chk_eq("b2b_starts", 32'(start_cyc.size() - n0), 32'd2);
      next_cycle();

      // Reset one cycle into an FADD
      FPStart = 1'b1;
      Funct7 = F7_FADD;
      RdIn = 5'd9;
      @(negedge clk);
      chk_eq("rst_add_ustart", 32'(UnitStart), 1);
      next_cycle();
      FPStart = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk_all_zero("rst_mid");
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      chk_all_zero("rst_after");
      next_cycle();
      UnitResult = 32'h7777_7777;
      next_cycle();
      UnitResult = JUNK;
      repeat (2) next_cycle();
      fp_op(F7_FADD, 5'd10, 32'h3F80_0000, 3, UOP_ADD, 1'b0);
      FPStart = 1'b0;

      repeat (4) next_cycle();
      chk_eq("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fpu_seq.md
# fpu_seq

Multi-cycle sequencer for FP R-type arithmetic (opcode 1010011: FADD.S/FSUB.S/FMUL.S/FDIV.S). It sits beside the main decoder and is the execution-side responder to the decoder's FP-op indication. It launches the op on a fixed-latency FP datapath and stalls the front end until the result is ready. It then captures the result and issues a one-cycle FP register-file write.

## Interface
Parameters:
- ADD_LAT, default 3: cycles from launch to valid result for FADD.S/FSUB.S; must be ≥1.
- MUL_LAT, default 4: same, for FMUL.S; must be ≥1.
- DIV_LAT, default 12: same, for FDIV.S; must be ≥1.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high.
- FPStart, in, 1: decode-stage instruction is FP R-type (RegWrite=1, ALUOp=11).
- Funct7, in, 7: instruction[31:25].
- RdIn, in, 5: destination FP register.
- Flush, in, 1: kill the in-flight op; synchronous.
- Stall, out, 1: hold the fetch and decode stages.
- UnitStart, out, 1: one-cycle launch pulse to the FP datapath.
- UnitOp, out, 2: 00 add, 01 sub, 10 mul, 11 div.
- UnitResult, in, 32: FP datapath result; valid exactly LAT cycles after UnitStart.
- FRegWrite, out, 1: FP register-file write enable.
- FRd, out, 5: write address.
- FResult, out, 32: write data.
- IllegalOp, out, 1: one-cycle pulse when FPStart is asserted with an unsupported Funct7.

## Operation
- Legal Funct7 codes: 0000000 FADD, 0000100 FSUB, 0001000 FMUL, 0001100 FDIV. Every other code is illegal.
- States: IDLE, RUN, WB.
- **IDLE**
  - FPStart & legal & !Flush:
    - Combinationally assert Stall=1, UnitStart=1, and UnitOp decoded from Funct7.
    - Latch UnitOp and RdIn.
    - Load the counter with LAT−1 for the op.
    - Next state RUN.
  - FPStart & illegal: IllegalOp=1 for that cycle; Stall=0; stay in IDLE.
- **RUN**
  - Stall=1.
  - When count≠0, decrement the counter.
  - When count==0, register UnitResult into FResult and go to WB.
- **WB**
  - FRegWrite=1, with FRd and FResult from the latched values.
  - Stall=0, so the stalled instruction advances this cycle.
  - FPStart is ignored in WB, because it still belongs to the retiring instruction.
  - Next state is always IDLE.
- **Flush** (any state)
  - Next state IDLE; no FRegWrite is issued for the killed op.
  - Stall=0 and UnitStart=0 in the flush cycle.
  - Flush has priority over FPStart in the same cycle.
  - A launched datapath op is simply abandoned.
- **reset**: same effect as Flush. All registers clear: FRd=0, FResult=0, counter=0.
- All outputs are 0 while reset is high and in IDLE with no FPStart.
- Counter width is $clog2(max LAT + 1). No wrap-around: the counter is reloaded only from IDLE.
- UnitOp is held stable in RUN, from the latched value.

## Timing
- Legal FPStart sampled at cycle T:
  - UnitStart at T.
  - RUN spans T+1 … T+LAT.
  - FResult is captured at the T+LAT edge.
  - WB at T+LAT+1.
- Stall is high for LAT+1 cycles (T … T+LAT) and low at T+LAT+1.
- With LAT=1, RUN lasts exactly one cycle.
- Back-to-back FP ops: the next FPStart is accepted in the IDLE cycle after WB. Minimum issue interval is LAT+2.
- FRegWrite is high for exactly one cycle per completed op.
- An illegal op produces zero stall cycles.

## Structure
- Shared package fpu_pkg holds:
  - The FP opcode constant 1010011.
  - The four Funct7 constants.
  - The UnitOp encodings.
  - The fpu_seq state enum.
- Single module. The counter and Funct7 decode are inline; no sub-module.

## Test plan
- FADD (Funct7=0000000, Rd=5, UnitResult=0x40400000 at T+3), default parameters → UnitStart at T; Stall high for 4 cycles; FRegWrite at T+4 with FRd=5, FResult=0x40400000.
- FDIV (0001100) → UnitOp=11; Stall high for 13 cycles; FRegWrite at T+13; FPStart held during WB produces no relaunch.
- Flush asserted at T+2 of an FMUL → IDLE at T+3; Stall=0 from T+2; no FRegWrite at any point.
- Funct7=0000001 with FPStart → IllegalOp pulse for 1 cycle; Stall=0; UnitStart=0; state stays IDLE.
- FSUB immediately followed by FADD (FPStart held) → second UnitStart exactly 5 cycles after the first; UnitOp 01 then 00; two single-cycle FRegWrite pulses.
- reset asserted at T+1 of an FADD → all outputs 0 next cycle; no FRegWrite; a new FADD after reset deasserts completes normally.
